// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection.
// Stalls the PC and inserts an ID/EX bubble for one cycle per load-use pair.
module if_id_stage #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ia,
  input  logic [31:0]            instr_in,
  input  logic                   flush,
  input  logic                   idex_mem_read,
  input  logic [4:0]             idex_rt,
  output logic                   pc_advance,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rt_is_src;
  logic       hazard;
  logic       stall;

  always_comb begin
    op        = instr_q[31:26];
    rs        = instr_q[25:21];
    rt        = instr_q[20:16];
    rt_is_src = (op == 6'h00) | (op == 6'h04) |
                (op == 6'h05) | (op == 6'h2B);
    hazard    = valid_q & idex_mem_read &
                (idex_rt != 5'd0) &
                ((idex_rt == rs) |
                 (rt_is_src & (idex_rt == rt)));
    // STALL state never re-stalls: the bubble already split load and use
    stall     = (state_q == RUN) & hazard &
                ~flush & ~reset;
  end

  always_comb begin
    state_d = RUN;
    pc_d    = ia;
    instr_d = instr_in;
    valid_d = 1'b1;
    cnt_d   = cnt_q;
    unique case (1'b1)
      flush: begin
        pc_d    = ia;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        state_d = RUN;
      end
      stall: begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        state_d = STALL;
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + STALL_CNT_W'(1);
        end
      end
      default: begin
        pc_d    = ia;
        instr_d = instr_in;
        valid_d = 1'b1;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= 32'h0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_advance  = ~stall;
  assign idex_bubble = stall;
  assign if_id_pc    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus queues expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_if_id_stage;

  localparam int W = 2;

  logic         clk;
  logic         reset;
  logic [31:0]  ia;
  logic [31:0]  instr_in;
  logic         flush;
  logic         idex_mem_read;
  logic [4:0]   idex_rt;
  logic         pc_advance;
  logic [31:0]  if_id_pc;
  logic [31:0]  if_id_instr;
  logic         if_id_valid;
  logic         idex_bubble;
  logic [W-1:0] stall_count;

  if_id_stage #(
    .STALL_CNT_W(W),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ia(ia),
    .instr_in(instr_in),
    .flush(flush),
    .idex_mem_read(idex_mem_read),
    .idex_rt(idex_rt),
    .pc_advance(pc_advance),
    .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid),
    .idex_bubble(idex_bubble),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        adv;
    logic        bub;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (pc_advance !== e.adv || idex_bubble !== e.bub ||
          if_id_pc !== e.pc || if_id_instr !== e.instr ||
          if_id_valid !== e.valid || stall_count !== e.cnt) begin
        bad++;
        $display("FAIL %s: got adv=%b bub=%b pc=%h ins=%h v=%b cnt=%0d want adv=%b bub=%b pc=%h ins=%h v=%b cnt=%0d",
          e.name, pc_advance, idex_bubble, if_id_pc, if_id_instr,
          if_id_valid, stall_count, e.adv, e.bub, e.pc, e.instr,
          e.valid, e.cnt);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] ins,
                     input logic fl, input logic mr,
                     input logic [4:0] rt);
    ia            = a;
    instr_in      = ins;
    flush         = fl;
    idex_mem_read = mr;
    idex_rt       = rt;
  endtask

  task automatic exp(input string n, input logic adv,
                     input logic bub, input logic [31:0] pc,
                     input logic [31:0] ins, input logic v,
                     input logic [W-1:0] c);
    exp_t e;
    e.name  = n;
    e.adv   = adv;
    e.bub   = bub;
    e.pc    = pc;
    e.instr = ins;
    e.valid = v;
    e.cnt   = c;
    q.push_back(e);
  endtask

  localparam logic [31:0] ADD_RS8 = 32'h010A4820;
  localparam logic [31:0] SW_RT8  = 32'hAD280000;
  localparam logic [31:0] ADDI    = 32'h21280001;
  localparam logic [31:0] ZREAD   = 32'h00004020;
  localparam logic [31:0] ADD99   = 32'h01295020;
  localparam logic [31:0] BASE    = 32'h0040_0000;

  initial begin
    reset = 1'b1;
    drv(32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    nxt();
    drv(32'h0, 32'h0, 1'b0, 1'b1, 5'd8);
    exp("reset", 1, 0, 32'h0, 32'h0, 0, 0);
    nxt();
    reset = 1'b0;
    drv(32'h8000_0000, 32'h2008_0005, 1'b0, 1'b0, 5'd0);
    exp("release", 1, 0, 32'h0, 32'h0, 0, 0);
    nxt();
    drv(32'h8000_0004, ADD_RS8, 1'b0, 1'b0, 5'd0);
    exp("capture", 1, 0, 32'h8000_0000, 32'h2008_0005, 1, 0);
    nxt();
    drv(32'h8000_0008, ADD99, 1'b0, 1'b1, 5'd8);
    exp("rs_stall", 0, 1, 32'h8000_0004, ADD_RS8, 1, 0);
    nxt();
    exp("stall_once", 1, 0, 32'h8000_0004, ADD_RS8, 1, 1);
    nxt();
    exp("next_cap", 1, 0, 32'h8000_0008, ADD99, 1, 1);
    drv(32'h8000_000C, SW_RT8, 1'b0, 1'b0, 5'd0);
    nxt();
    drv(32'h8000_0010, ADDI, 1'b0, 1'b1, 5'd8);
    exp("sw_rt_stall", 0, 1, 32'h8000_000C, SW_RT8, 1, 1);
    nxt();
    drv(32'h8000_0010, ADDI, 1'b0, 1'b0, 5'd0);
    exp("sw_hold", 1, 0, 32'h8000_000C, SW_RT8, 1, 2);
    nxt();
    drv(32'h8000_0014, ZREAD, 1'b0, 1'b1, 5'd8);
    exp("addi_rt_dst", 1, 0, 32'h8000_0010, ADDI, 1, 2);
    nxt();
    drv(32'h8000_0018, ADD_RS8, 1'b0, 1'b1, 5'd0);
    exp("zero_reg", 1, 0, 32'h8000_0014, ZREAD, 1, 2);
    nxt();
    drv(32'h8000_001C, 32'h1234_5678, 1'b1, 1'b1, 5'd8);
    exp("flush_hazard", 1, 0, 32'h8000_0018, ADD_RS8, 1, 2);
    nxt();
    drv(32'h8000_0020, ADD_RS8, 1'b0, 1'b1, 5'd8);
    exp("flushed", 1, 0, 32'h8000_001C, 32'h0, 0, 2);
    nxt();
    reset = 1'b1;
    exp("reset2", 1, 0, 32'h0, 32'h0, 0, 0);
    nxt();
    reset = 1'b0;
    drv(BASE, ADD_RS8, 1'b0, 1'b1, 5'd8);
    exp("release2", 1, 0, 32'h0, 32'h0, 0, 0);
    begin
      logic [W-1:0] c;
      c = '0;
      for (int i = 0; i < 5; i++) begin
        nxt();
        exp($sformatf("sat_stall%0d", i), 0, 1, BASE, ADD_RS8, 1, c);
        if (c != 2'd3) c = c + 2'd1;
        nxt();
        exp($sformatf("sat_cnt%0d", i), 1, 0, BASE, ADD_RS8, 1, c);
      end
      nxt();
      exp("stall6", 0, 1, BASE, ADD_RS8, 1, c);
    end
    nxt();
    reset = 1'b1;
    exp("rst_mid_stall", 1, 0, 32'h0, 32'h0, 0, 0);
    nxt();
    reset = 1'b0;
    drv(BASE + 32'h4, ADDI, 1'b0, 1'b0, 5'd0);
    exp("release3", 1, 0, 32'h0, 32'h0, 0, 0);
    nxt();
    exp("post_reset_cap", 1, 0, BASE + 32'h4, ADDI, 1, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline stage directly downstream of the program counter. Each cycle it captures the fetch address and the instruction-memory word into the IF/ID register.
- Contains the load-use hazard detector. It drives the PC advance-enable, holds the IF/ID register, and requests an ID/EX bubble when the decoded instruction needs a register still being loaded in EX.
- Taken branches and jumps from later stages flush the stage.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall performance counter.
- NOP_WORD, 32'h00000000, instruction word substituted on flush/reset (sll $0,$0,0).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- ia  input  32  current fetch address from the PC.
- instr_in  input  32  instruction-memory word at ia (combinational, same cycle).
- flush  input  1  taken branch/jump resolved downstream; squash the IF/ID contents.
- idex_mem_read  input  1  instruction in EX is a load.
- idex_rt  input  5  destination register of the load in EX.
- pc_advance  output  1  to the PC's enable input; 1 = PC += 4 this edge, 0 = hold.
- if_id_pc  output  32  registered fetch address.
- if_id_instr  output  32  registered instruction.
- if_id_valid  output  1  registered instruction is real (not bubble/reset).
- idex_bubble  output  1  ID/EX must load a NOP/zero control word this edge.
- stall_count  output  STALL_CNT_W  number of load-use stall cycles since reset, saturating.

Behaviour:
- Reset (async, immediate): if_id_pc=0, if_id_instr=NOP_WORD, if_id_valid=0, state=RUN, stall_count=0. While reset is high, pc_advance=1 and idex_bubble=0.
- Field decode from if_id_instr:
  - rs=[25:21], rt=[20:16], op=[31:26].
  - rt_is_src when op is 6'h00 (R-type), 6'h04 (beq), 6'h05 (bne) or 6'h2B (sw).
- hazard = if_id_valid & idex_mem_read & (idex_rt!=0) & ((idex_rt==rs) | (rt_is_src & idex_rt==rt)).
- FSM states RUN and STALL:
  - RUN: if hazard & !flush, then stall: pc_advance=0, idex_bubble=1, IF/ID register holds, stall_count increments, next state=STALL. Otherwise normal operation.
  - STALL: lasts exactly one cycle. It never raises a second stall even if hazard is still true (the bubble has already separated load and use). pc_advance=1, normal capture, next state=RUN.
- Normal operation (not stalling, no flush): at each clk edge if_id_pc<=ia, if_id_instr<=instr_in, if_id_valid<=1; pc_advance=1, idex_bubble=0.
- Flush has priority over stall in any state:
  - if_id_instr<=NOP_WORD, if_id_valid<=0, if_id_pc<=ia.
  - pc_advance=1, idex_bubble=0, next state=RUN, no count increment.
- pc_advance and idex_bubble are combinational from the registered state and current inputs, valid in the same cycle. There are no combinational paths from ia or instr_in to any output.
- stall_count saturates at all-ones and never wraps.
- Reset mid-stall: all state clears immediately. The first edge after reset release performs a normal capture.

Test Plan:
- Reset/capture: assert reset, release; ia=0x80000000, instr_in=0x20080005 -> after edge if_id_pc=0x80000000, if_id_instr=0x20080005, valid=1; pc_advance=1 throughout.
- RS load-use: IF/ID holds add $9,$8,$10 (0x010A4820); idex_mem_read=1, idex_rt=8 -> pc_advance=0 and idex_bubble=1 for exactly one cycle, IF/ID unchanged, stall_count=1. Next cycle, with the inputs held, pc_advance=1 and the next instruction is captured.
- RT source vs dest:
  - sw $8,0($9) (0xAD280000) with idex_rt=8 -> stall.
  - addi $8,$9,1 (0x21280001) with idex_rt=8 -> no stall (rt is a destination).
- Zero register: idex_rt=0, instruction reads $0, idex_mem_read=1 -> no stall, count stays 0.
- Flush over hazard: hazard conditions true and flush=1 -> pc_advance=1, idex_bubble=0, after edge if_id_instr=0, valid=0, count unchanged.
- Saturation: STALL_CNT_W=2, force 5 separate load-use stalls -> stall_count reads 1,2,3,3,3. Asynchronous reset mid-STALL -> count=0, valid=0 immediately.
